idiv_int_div_base_rtl: RTL and testbench



---
 rtl/idiv_pkg.sv | 41 ++++
 rtl/idiv_int_div_base_dpath.sv | 91 +++++++++
 rtl/idiv_int_div_base_rtl.sv | 84 ++++++++
 tb/tb_idiv_int_div_base_rtl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/idiv_pkg.sv
// rtl/idiv_pkg.sv - shared types, mux selects and field offsets for the iterative divider
package idiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic RQ_SEL_LOAD  = 1'b0;
  localparam logic RQ_SEL_SHIFT = 1'b1;
  localparam logic ST_SEL_KEEP  = 1'b0;
  localparam logic ST_SEL_SUB   = 1'b1;
  localparam logic RES_SEL_DIV  = 1'b0;
  localparam logic RES_SEL_ZERO = 1'b1;

  // Control-table column order, msb first
  localparam int CS_REQ_RDY  = 5;
  localparam int CS_RESP_VAL = 4;
  localparam int CS_RQ_EN    = 3;
  localparam int CS_RQ_SEL   = 2;
  localparam int CS_CNT_CLR  = 1;
  localparam int CS_CNT_INC  = 0;
  localparam int CS_W        = 6;

  localparam int REQ_B_LSB     = 0;
  localparam int RESP_QUOT_LSB = 0;

  function automatic int req_sign_bit(input int nbits);
    return 2 * nbits;
  endfunction

  function automatic int req_a_lsb(input int nbits);
    return nbits;
  endfunction

  function automatic int resp_rem_lsb(input int nbits);
    return nbits;
  endfunction

endpackage

// File: rtl/idiv_int_div_base_dpath.sv
// rtl/idiv_int_div_base_dpath.sv - divider datapath: operand magnitudes, restoring step, sign fix-up
module idiv_int_div_base_dpath
  import idiv_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2*NBITS:0]   i_req_msg,
  input  logic               i_rq_en,
  input  logic               i_rq_sel,
  input  logic               i_st_sel,
  input  logic               i_res_sel,
  input  logic               i_resp_en,
  output logic               o_diff_msb,
  output logic               o_b_is_zero,
  output logic [2*NBITS-1:0] o_resp_msg
);

  localparam int N        = NBITS;
  localparam int SIGN_BIT = req_sign_bit(N);
  localparam int A_LSB    = req_a_lsb(N);
  localparam int REM_LSB  = resp_rem_lsb(N);

  logic         r_is_signed, r_sign_a, r_sign_b;
  logic [N-1:0] r_a_raw, r_b_raw, r_divisor;
  logic [2*N:0] r_rq;

  logic         w_sgn;
  logic [N-1:0] w_a, w_b, w_a_abs, w_b_abs;
  logic [N+1:0] w_upper, w_diff;
  logic [N-1:0] w_quot, w_rem, w_quot_fix, w_rem_fix;
  logic         w_sub;

  assign w_sgn   = i_req_msg[SIGN_BIT];
  assign w_a     = i_req_msg[A_LSB +: N];
  assign w_b     = i_req_msg[REQ_B_LSB +: N];
  assign w_a_abs = (w_sgn && w_a[N-1]) ? -w_a : w_a;
  assign w_b_abs = (w_sgn && w_b[N-1]) ? -w_b : w_b;

  // One extra guard bit so the whole shifted upper half is visible to the subtractor
  assign w_upper     = r_rq[2*N:N-1];
  assign w_diff      = w_upper - {2'b00, r_divisor};
  assign o_diff_msb  = w_diff[N+1];
  assign o_b_is_zero = (r_b_raw == '0);
  assign w_sub       = (i_st_sel == ST_SEL_SUB);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_is_signed <= 1'b0;
      r_sign_a    <= 1'b0;
      r_sign_b    <= 1'b0;
      r_a_raw     <= '0;
      r_b_raw     <= '0;
      r_divisor   <= '0;
      r_rq        <= '0;
    end else if (i_rq_en) begin
      if (i_rq_sel == RQ_SEL_LOAD) begin
        r_is_signed <= w_sgn;
        r_sign_a    <= w_a[N-1];
        r_sign_b    <= w_b[N-1];
        r_a_raw     <= w_a;
        r_b_raw     <= w_b;
        r_divisor   <= w_b_abs;
        r_rq        <= {{(N+1){1'b0}}, w_a_abs};
      end else begin
        r_rq <= {(w_sub ? w_diff[N:0] : w_upper[N:0]), r_rq[N-2:0], w_sub};
      end
    end
  end

  assign w_quot     = r_rq[N-1:0];
  assign w_rem      = r_rq[2*N-1:N];
  assign w_quot_fix = (r_is_signed && (r_sign_a ^ r_sign_b)) ? -w_quot : w_quot;
  assign w_rem_fix  = (r_is_signed && r_sign_a) ? -w_rem : w_rem;

  // Held at zero outside DONE so the reset view of the response is all zeros
  always_comb begin
    o_resp_msg = '0;
    if (i_resp_en) begin
      if (i_res_sel == RES_SEL_ZERO) begin
        o_resp_msg[REM_LSB +: N]       = r_a_raw;
        o_resp_msg[RESP_QUOT_LSB +: N] = '1;
      end else begin
        o_resp_msg[REM_LSB +: N]       = w_rem_fix;
        o_resp_msg[RESP_QUOT_LSB +: N] = w_quot_fix;
      end
    end
  end

endmodule

// File: rtl/idiv_int_div_base_rtl.sv
// rtl/idiv_int_div_base_rtl.sv - iterative restoring divider top: control FSM, iteration counter, datapath
module idiv_int_div_base_rtl
  import idiv_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_req_val,
  output logic               o_req_rdy,
  input  logic [2*NBITS:0]   i_req_msg,
  output logic               o_resp_val,
  input  logic               i_resp_rdy,
  output logic [2*NBITS-1:0] o_resp_msg
);

  localparam int CNT_W = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBITS - 1);

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CS_W-1:0]  w_cs;
  logic             w_diff_msb, w_b_is_zero, w_st_sel, w_res_sel;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset || w_cs[CS_CNT_CLR]) r_cnt <= '0;
    else if (w_cs[CS_CNT_INC])     r_cnt <= r_cnt + CNT_W'(1);
  end

  always_comb begin
    w_state_next = r_state;
    w_cs         = '0;
    case (r_state)
      IDLE: begin
        w_cs[CS_REQ_RDY] = 1'b1;
        w_cs[CS_RQ_EN]   = i_req_val;
        w_cs[CS_RQ_SEL]  = RQ_SEL_LOAD;
        w_cs[CS_CNT_CLR] = 1'b1;
        if (i_req_val) w_state_next = CALC;
      end
      CALC: begin
        w_cs[CS_RQ_EN]   = 1'b1;
        w_cs[CS_RQ_SEL]  = RQ_SEL_SHIFT;
        w_cs[CS_CNT_INC] = 1'b1;
        if (r_cnt == CNT_LAST) w_state_next = DONE;
      end
      DONE: begin
        w_cs[CS_RESP_VAL] = 1'b1;
        if (i_resp_rdy) w_state_next = IDLE;
      end
      default: begin
        w_state_next = state_t'(2'bxx);
        w_cs         = 'x;
      end
    endcase
  end

  assign o_req_rdy  = w_cs[CS_REQ_RDY];
  assign o_resp_val = w_cs[CS_RESP_VAL];
  assign w_st_sel   = w_diff_msb ? ST_SEL_KEEP : ST_SEL_SUB;
  assign w_res_sel  = w_b_is_zero ? RES_SEL_ZERO : RES_SEL_DIV;

  idiv_int_div_base_dpath #(
    .NBITS(NBITS)
  ) u_dpath (
    .clk        (clk),
    .reset      (reset),
    .i_req_msg  (i_req_msg),
    .i_rq_en    (w_cs[CS_RQ_EN]),
    .i_rq_sel   (w_cs[CS_RQ_SEL]),
    .i_st_sel   (w_st_sel),
    .i_res_sel  (w_res_sel),
    .i_resp_en  (w_cs[CS_RESP_VAL]),
    .o_diff_msb (w_diff_msb),
    .o_b_is_zero(w_b_is_zero),
    .o_resp_msg (o_resp_msg)
  );

endmodule

// File: tb/tb_idiv_int_div_base_rtl.sv
// tb/tb_idiv_int_div_base_rtl.sv - directed and streaming checks for the iterative divider
module tb_idiv_int_div_base_rtl;

  localparam int NBITS = 32;

  logic               clk, reset;
  logic               req_val, req_rdy, resp_val, resp_rdy;
  logic [2*NBITS:0]   req_msg;
  logic [2*NBITS-1:0] resp_msg;

  int n_checks = 0;
  int n_pass   = 0;

  idiv_int_div_base_rtl #(.NBITS(NBITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req_val (req_val),
    .o_req_rdy (req_rdy),
    .i_req_msg (req_msg),
    .o_resp_val(resp_val),
    .i_resp_rdy(resp_rdy),
    .o_resp_msg(resp_msg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    return {r, q};
  endfunction

  task automatic send_req(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int cyc;
    cyc = 0;
    while (!req_rdy && cyc < 200) begin
      step();
      cyc++;
    end
    if (!req_rdy) check("req_rdy_timeout", req_rdy, 1);
    req_val = 1'b1;
    req_msg = {sgn, a, b};
    step();
    req_val = 1'b0;
  endtask

  task automatic wait_resp(output int cyc);
    cyc = 1;
    while (!resp_val && cyc < 100) begin
      step();
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int cyc;
    send_req(sgn, a, b);
    wait_resp(cyc);
    check({tag, "_lat"}, cyc, 33);
    check({tag, "_msg"}, resp_msg, exp);
    resp_rdy = 1'b1;
    step();
    resp_rdy = 1'b0;
  endtask

  initial begin
    int          cyc, seen;
    logic        sgn;
    logic [31:0] a, b;

    reset    = 1'b1;
    req_val  = 1'b0;
    req_msg  = '0;
    resp_rdy = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    check("rst_req_rdy", req_rdy, 1);
    check("rst_resp_val", resp_val, 0);
    check("rst_resp_msg", resp_msg, 0);

    run_op("u_100_7",      1'b0, 32'd100,       32'd7,         {32'h0000_0002, 32'h0000_000E});
    run_op("s_m7_2",       1'b1, 32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("s_7_m2",       1'b1, 32'd7,         32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD});
    run_op("s_m100_m7",    1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'h0000_000E});
    run_op("u_div0",       1'b0, 32'd5,         32'd0,         {32'h0000_0005, 32'hFFFF_FFFF});
    run_op("s_div0",       1'b1, 32'hFFFF_FFFB, 32'd0,         {32'hFFFF_FFFB, 32'hFFFF_FFFF});
    run_op("s_ovf",        1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000});
    run_op("u_ovf_ops",    1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0000_0000});
    run_op("u_max_1",      1'b0, 32'hFFFF_FFFF, 32'd1,         {32'h0000_0000, 32'hFFFF_FFFF});
    run_op("s_0_5",        1'b1, 32'd0,         32'd5,         {32'h0000_0000, 32'h0000_0000});

    // Back-pressure: hold the response while a competing request is offered
    send_req(1'b0, 32'd1000, 32'd3);
    wait_resp(cyc);
    check("bp_lat", cyc, 33);
    req_val = 1'b1;
    req_msg = {1'b0, 32'd50, 32'd5};
    for (int i = 0; i < 10; i++) begin
      check("bp_val", resp_val, 1);
      check("bp_msg", resp_msg, {32'd1, 32'd333});
      check("bp_rdy", req_rdy, 0);
      step();
    end
    req_val  = 1'b0;
    resp_rdy = 1'b1;
    step();
    resp_rdy = 1'b0;
    check("bp_idle_rdy", req_rdy, 1);
    check("bp_idle_val", resp_val, 0);

    resp_rdy = 1'b1;
    for (int i = 0; i < 500; i++) begin
      repeat ($urandom_range(0, 3)) step();
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = $urandom_range(0, 15);
        2:       b = -$urandom_range(1, 15);
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 15) == 0) a = 32'h8000_0000;
      send_req(sgn, a, b);
      wait_resp(cyc);
      if (!resp_val) check($sformatf("rand%0d_timeout", i), resp_val, 1);
      check($sformatf("rand%0d", i), resp_msg, model(sgn, a, b));
      step();
    end
    resp_rdy = 1'b0;

    // Reset partway through the iterations
    send_req(1'b0, 32'h1234_5678, 32'd3);
    repeat (9) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_req_rdy", req_rdy, 1);
    check("midrst_resp_val", resp_val, 0);
    check("midrst_resp_msg", resp_msg, 0);
    seen = 0;
    repeat (40) begin
      step();
      if (resp_val) seen++;
    end
    check("midrst_no_stale", seen, 0);
    run_op("midrst_fresh", 1'b0, 32'hFFFF_FFFF, 32'h10, {32'h0000_000F, 32'h0FFF_FFFF});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
